regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 96 +++++++++
 tb/tb_regfile_sb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-register busy (reservation) scoreboard; reg 0 reads as zero.
// Latency: reads and busy flags are combinational with write bypass; updates land on the rising edge.
// Backpressure: none; every write and reserve is accepted in its cycle, reserve wins over a same-index write.
module regfile_sb #(
  parameter int          XLEN    = 64,
  parameter int          NREGS   = 32,
  parameter int          NRD     = 2,
  parameter int          SP_ID   = 2,
  parameter logic [63:0] SP_INIT = 64'h10000,
  localparam int         IDW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*IDW-1:0]  rd_id,
  output logic [NRD*XLEN-1:0] rd_val,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [IDW-1:0]      wr_id,
  input  logic [XLEN-1:0]     wr_val,
  input  logic                rsv_en,
  input  logic [IDW-1:0]      rsv_id,
  output logic [IDW:0]        busy_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [IDW:0]     r_busy_cnt;

  logic             w_wr_ok;
  logic             w_rsv_ok;
  logic [NREGS-1:0] w_busy_nxt;
  logic [IDW:0]     w_cnt_nxt;

  // Index 0 and anything past the last register alias the hardwired-zero register.
  function automatic logic id_ok(input logic [IDW-1:0] id);
    return (id != '0) && (int'(id) < NREGS);
  endfunction

  // Writes and reserves are dropped while reset is held, so reset contents show through.
  assign w_wr_ok  = we && !rst && id_ok(wr_id);
  assign w_rsv_ok = rsv_en && !rst && id_ok(rsv_id);

  // Next busy vector: a write retires the producer, a reserve (applied last) installs a new one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) w_busy_nxt[wr_id] = 1'b0;
    if (w_rsv_ok) w_busy_nxt[rsv_id] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{IDW{1'b0}}, w_busy_nxt[i]};
    end
  end

  // Data registers; reset loads zeros except the stack pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == SP_ID && i != 0) ? XLEN'(SP_INIT) : '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_id] <= wr_val;
    end
  end

  // Busy vector and its population count are registered together so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  // Read ports: same-cycle write data bypasses the array; busy follows the pending reserve then.
  always_comb begin
    rd_val  = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (id_ok(rd_id[k*IDW +: IDW])) begin
        if (w_wr_ok && (wr_id == rd_id[k*IDW +: IDW])) begin
          rd_val[k*XLEN +: XLEN] = wr_val;
          rd_busy[k]             = w_rsv_ok && (rsv_id == wr_id);
        end else begin
          rd_val[k*XLEN +: XLEN] = r_regs[rd_id[k*IDW +: IDW]];
          rd_busy[k]             = r_busy[rd_id[k*IDW +: IDW]];
        end
      end
    end
  end

  assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against an array model.
module tb_regfile_sb;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int IDW   = 5;

  logic                clk = 1'b0;
  logic                clk_run = 1'b0;
  logic                rst = 1'b0;
  logic [NRD*IDW-1:0]  rd_id;
  logic [NRD*XLEN-1:0] rd_val;
  logic [NRD-1:0]      rd_busy;
  logic                we;
  logic [IDW-1:0]      wr_id;
  logic [XLEN-1:0]     wr_val;
  logic                rsv_en;
  logic [IDW-1:0]      rsv_id;
  logic [IDW:0]        busy_cnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_regs [NREGS];
  bit          m_busy [NREGS];

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rd_id    (rd_id),
    .rd_val   (rd_val),
    .rd_busy  (rd_busy),
    .we       (we),
    .wr_id    (wr_id),
    .wr_val   (wr_val),
    .rsv_en   (rsv_en),
    .rsv_id   (rsv_id),
    .busy_cnt (busy_cnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_regs[2] = 64'h10000;
  endtask

  // Model of one rising edge: a write retires the producer, then a reserve marks a new one.
  task automatic m_edge();
    if (we && wr_id != 0) begin
      m_regs[wr_id] = wr_val;
      m_busy[wr_id] = 1'b0;
    end
    if (rsv_en && rsv_id != 0) m_busy[rsv_id] = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    logic [IDW-1:0] id;
    logic [63:0]    ev;
    bit             eb;
    for (int k = 0; k < NRD; k++) begin
      id = rd_id[k*IDW +: IDW];
      if (id == 0) begin
        ev = '0;
        eb = 1'b0;
      end else if (!rst && we && wr_id == id) begin
        ev = wr_val;
        eb = rsv_en && rsv_id == wr_id;
      end else begin
        ev = m_regs[id];
        eb = m_busy[id];
      end
      chk($sformatf("%s_val%0d", tag, k), rd_val[k*XLEN +: XLEN], ev);
      chk($sformatf("%s_busy%0d", tag, k), 64'(rd_busy[k]), 64'(eb));
    end
    chk($sformatf("%s_cnt", tag), 64'(busy_cnt), 64'(m_cnt()));
  endtask

  task automatic idle();
    we     = 1'b0;
    wr_id  = '0;
    wr_val = '0;
    rsv_en = 1'b0;
    rsv_id = '0;
  endtask

  task automatic set_rd(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    rd_id = {b, a};
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    idle();
    set_rd(5'd2, 5'd5);

    // Reset with the clock stopped; a write presented during reset must not bypass.
    #1;
    rst = 1'b1;
    m_reset();
    we = 1'b1; wr_id = 5'd2; wr_val = 64'h55;
    #2;
    chk("rst_sp_during", rd_val[63:0], 64'h10000);
    chk("rst_r5_during", rd_val[127:64], 64'h0);
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_sp", rd_val[63:0], 64'h10000);
    chk("rst_r5", rd_val[127:64], 64'h0);
    chk("rst_busy", 64'(rd_busy), 64'h0);
    chk("rst_cnt", 64'(busy_cnt), 64'h0);

    clk_run = 1'b1;
    @(negedge clk);

    // Write with same-cycle bypass.
    set_rd(5'd5, 5'd2);
    we = 1'b1; wr_id = 5'd5; wr_val = 64'hDEAD_BEEF;
    #1;
    chk("byp_before", rd_val[63:0], 64'hDEAD_BEEF);
    check_outputs("byp");
    tick();
    idle();
    #1;
    chk("byp_after", rd_val[63:0], 64'hDEAD_BEEF);

    // Register 0 ignores writes and reserves.
    set_rd(5'd0, 5'd0);
    we = 1'b1; wr_id = 5'd0; wr_val = 64'h1234;
    rsv_en = 1'b1; rsv_id = 5'd0;
    #1;
    check_outputs("x0_pre");
    tick();
    idle();
    #1;
    chk("x0_val", rd_val[63:0], 64'h0);
    chk("x0_busy", 64'(rd_busy), 64'h0);
    chk("x0_cnt", 64'(busy_cnt), 64'h0);

    // Scoreboard: reserve 7, 9, 7 again.
    rsv_en = 1'b1; rsv_id = 5'd7; tick();
    rsv_id = 5'd9; tick();
    rsv_id = 5'd7; tick();
    idle();
    set_rd(5'd7, 5'd9);
    #1;
    chk("sb_cnt2", 64'(busy_cnt), 64'd2);
    chk("sb_busy79", 64'(rd_busy), 64'b11);
    we = 1'b1; wr_id = 5'd7; wr_val = 64'h77;
    tick();
    idle();
    #1;
    chk("sb_b7", 64'(rd_busy[0]), 64'd0);
    chk("sb_b9", 64'(rd_busy[1]), 64'd1);
    chk("sb_cnt1", 64'(busy_cnt), 64'd1);
    chk("sb_v7", rd_val[63:0], 64'h77);

    // Simultaneous reserve and write to 9: data lands, stays busy, count unchanged.
    we = 1'b1; wr_id = 5'd9; wr_val = 64'h99;
    rsv_en = 1'b1; rsv_id = 5'd9;
    set_rd(5'd9, 5'd7);
    #1;
    chk("rw_byp_busy", 64'(rd_busy[0]), 64'd1);
    tick();
    idle();
    #1;
    chk("rw_val", rd_val[63:0], 64'h99);
    chk("rw_busy", 64'(rd_busy[0]), 64'd1);
    chk("rw_cnt", 64'(busy_cnt), 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we     = 1'($urandom_range(0, 1));
      wr_id  = 5'($urandom_range(0, NREGS - 1));
      wr_val = {$urandom, $urandom};
      rsv_en = 1'($urandom_range(0, 1));
      rsv_id = ($urandom_range(0, 3) == 0) ? wr_id : 5'($urandom_range(0, NREGS - 1));
      set_rd(5'($urandom_range(0, NREGS - 1)), 5'($urandom_range(0, NREGS - 1)));
      if ($urandom_range(0, 2) == 0) rd_id[IDW-1:0] = wr_id;
      if ($urandom_range(0, 4) == 0) rd_id[2*IDW-1:IDW] = rd_id[IDW-1:0];
      #1;
      check_outputs("rnd");
      tick();
    end

    // Reset mid-operation abandons reservations without a clock edge.
    idle();
    rsv_en = 1'b1; rsv_id = 5'd3; tick();
    rsv_id = 5'd4; tick();
    rsv_id = 5'd5; tick();
    idle();
    set_rd(5'd3, 5'd4);
    #1;
    chk("mid_busy34", 64'(rd_busy), 64'b11);
    #1;
    rst = 1'b1;
    m_reset();
    #1;
    chk("mid_cnt", 64'(busy_cnt), 64'd0);
    chk("mid_r3", rd_val[63:0], 64'h0);
    chk("mid_busy", 64'(rd_busy), 64'h0);
    #1;
    rst = 1'b0;
    tick();
    set_rd(5'd5, 5'd2);
    #1;
    check_outputs("post_rst");

    // A little more traffic after reset.
    for (int n = 0; n < 50; n++) begin
      we     = 1'($urandom_range(0, 1));
      wr_id  = 5'($urandom_range(0, NREGS - 1));
      wr_val = {$urandom, $urandom};
      rsv_en = 1'($urandom_range(0, 1));
      rsv_id = 5'($urandom_range(0, NREGS - 1));
      set_rd(wr_id, 5'($urandom_range(0, NREGS - 1)));
      #1;
      check_outputs("rnd2");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
